// File: rtl/ser2par_align.sv
// Receive framer: hunts for K28.5 on any bit offset, confirms word alignment, then emits aligned 10-bit words.
// Outputs are registered; par_valid follows the boundary cycle by one clock. There is no backpressure.
module ser2par_align #(
    parameter int                 WIDTH      = 10,
    parameter logic [WIDTH-1:0]   COMMA_P    = 10'b0101111100,
    parameter logic [WIDTH-1:0]   COMMA_N    = 10'b1010000011,
    parameter int                 LOCK_COUNT = 3,
    parameter int                 LOSS_COUNT = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_ser_in,
    output logic [WIDTH-1:0] o_par_out,
    output logic             o_par_valid,
    output logic             o_par_is_comma,
    output logic             o_locked
);

    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int MW = $clog2(LOSS_COUNT + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [3:0]       r_bit_cnt;
    logic [3:0]       w_bit_cnt_nxt;
    logic [GW-1:0]    r_good_cnt;
    logic [GW-1:0]    w_good_nxt;
    logic [GW-1:0]    w_good_inc;
    logic [MW-1:0]    r_miss_cnt;
    logic [MW-1:0]    w_miss_nxt;
    logic [MW-1:0]    w_miss_inc;
    logic             w_comma_hit;
    logic             w_boundary;
    logic             w_emit;
    logic [WIDTH-1:0] r_par_out;
    logic             r_par_valid;
    logic             r_par_is_comma;
    logic             r_locked;

    assign w_comma_hit = (r_shreg == COMMA_P) || (r_shreg == COMMA_N);
    assign w_boundary  = (r_bit_cnt == 4'd9);
    assign w_good_inc  = r_good_cnt + 1'b1;
    assign w_miss_inc  = r_miss_cnt + 1'b1;

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = w_boundary ? 4'd0 : r_bit_cnt + 4'd1;
        w_good_nxt    = r_good_cnt;
        w_miss_nxt    = r_miss_cnt;
        w_emit        = 1'b0;
        case (r_state)
            HUNT: begin
                // Restart the word counter so the next boundary lands ten clocks after this comma.
                if (w_comma_hit) begin
                    w_bit_cnt_nxt = 4'd0;
                    w_good_nxt    = GW'(1);
                    w_state_nxt   = CHECK;
                end
            end
            CHECK: begin
                if (w_boundary) begin
                    if (w_comma_hit) begin
                        w_good_nxt = w_good_inc;
                        if (w_good_inc == GW'(LOCK_COUNT)) begin
                            w_state_nxt = LOCKED;
                            w_miss_nxt  = '0;
                        end
                    end else begin
                        w_state_nxt = HUNT;
                    end
                end
            end
            LOCKED: begin
                if (w_boundary) begin
                    w_emit = 1'b1;
                    if (w_comma_hit) begin
                        w_miss_nxt = '0;
                    end
                end else if (w_comma_hit) begin
                    w_miss_nxt = w_miss_inc;
                    if (w_miss_inc == MW'(LOSS_COUNT)) begin
                        w_state_nxt = HUNT;
                    end
                end
            end
            default: w_state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_shreg        <= '0;
            r_bit_cnt      <= 4'd0;
            r_good_cnt     <= '0;
            r_miss_cnt     <= '0;
            r_par_out      <= '0;
            r_par_valid    <= 1'b0;
            r_par_is_comma <= 1'b0;
            r_locked       <= 1'b0;
        end else begin
            r_shreg     <= {i_ser_in, r_shreg[WIDTH-1:1]};
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_good_cnt  <= w_good_nxt;
            r_miss_cnt  <= w_miss_nxt;
            r_par_valid <= w_emit;
            r_locked    <= (w_state_nxt == LOCKED);
            if (w_emit) begin
                r_par_out      <= r_shreg;
                r_par_is_comma <= w_comma_hit;
            end
        end
    end

    assign o_par_out      = r_par_out;
    assign o_par_valid    = r_par_valid;
    assign o_par_is_comma = r_par_is_comma;
    assign o_locked       = r_locked;

endmodule

// File: tb/tb_ser2par_align.sv
// Bench for ser2par_align: directed framing scenarios plus a random soak, all checked against a bit-history model.
module tb_ser2par_align;

    localparam logic [9:0] CP   = 10'b0101111100;
    localparam logic [9:0] CN   = 10'b1010000011;
    localparam logic [9:0] W023 = 10'h023;
    localparam int         NREC = 16384;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ser = 1'b0;
    logic [9:0] o_par_out;
    logic       o_par_valid;
    logic       o_par_is_comma;
    logic       o_locked;

    ser2par_align dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_ser_in       (ser),
        .o_par_out      (o_par_out),
        .o_par_valid    (o_par_valid),
        .o_par_is_comma (o_par_is_comma),
        .o_locked       (o_locked)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int t     = 0;
    int last_e = 0;

    logic       lk_at  [NREC];
    logic       vld_at [NREC];
    logic       isc_at [NREC];
    logic [9:0] out_at [NREC];

    // Reference: line history since reset, plus the cycle index of the comma that set the word phase.
    bit         m_hist[$];
    int         m_st = 0;
    int         m_anchor = 0;
    int         m_good = 0;
    int         m_miss = 0;
    logic [9:0] m_out = '0;
    logic       m_valid = 1'b0;
    logic       m_isc = 1'b0;
    logic       m_locked = 1'b0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    function automatic logic [9:0] m_window();
        logic [9:0] v = '0;
        int n = m_hist.size();
        for (int k = 0; k < 10; k++) begin
            if (n - 10 + k >= 0 && m_hist[n - 10 + k]) v[k] = 1'b1;
        end
        return v;
    endfunction

    task automatic model_step(input logic b, input logic r);
        logic [9:0] w;
        logic hit, aligned;
        if (r) begin
            m_hist.delete();
            m_st = 0; m_good = 0; m_miss = 0;
            m_out = '0; m_valid = 1'b0; m_isc = 1'b0; m_locked = 1'b0;
            return;
        end
        w       = m_window();
        hit     = (w == CP) || (w == CN);
        aligned = ((t - m_anchor) % 10) == 0;
        m_valid = 1'b0;
        case (m_st)
            0: if (hit) begin m_anchor = t; m_good = 1; m_st = 1; end
            1: if (aligned) begin
                if (hit) begin
                    m_good++;
                    if (m_good == 3) begin m_st = 2; m_miss = 0; m_locked = 1'b1; end
                end else m_st = 0;
            end
            default: begin
                if (aligned) begin
                    m_out = w; m_isc = hit; m_valid = 1'b1;
                    if (hit) m_miss = 0;
                end else if (hit) begin
                    m_miss++;
                    if (m_miss == 4) begin m_st = 0; m_locked = 1'b0; end
                end
            end
        endcase
        m_hist.push_back(b);
        if (m_hist.size() > 10) void'(m_hist.pop_front());
    endtask

    task automatic step(input logic b, input logic r);
        @(negedge clk);
        ser = b;
        rst = r;
        model_step(b, r);
        @(posedge clk);
        #1;
        if (t < NREC) begin
            lk_at[t]  = o_locked;
            vld_at[t] = o_par_valid;
            isc_at[t] = o_par_is_comma;
            out_at[t] = o_par_out;
        end
        chk_eq("m_locked", 32'(o_locked), 32'(m_locked));
        chk_eq("m_valid", 32'(o_par_valid), 32'(m_valid));
        chk_eq("m_par_out", 32'(o_par_out), 32'(m_out));
        chk_eq("m_is_comma", 32'(o_par_is_comma), 32'(m_isc));
        last_e = t;
        t++;
    endtask

    task automatic send_word(input logic [9:0] w);
        for (int i = 0; i < 10; i++) step(w[i], 1'b0);
    endtask

    function automatic int cnt_vld(input int a, input int b);
        int s = 0;
        for (int i = a; i <= b; i++) if (i >= 0 && i < NREC) s += int'(vld_at[i]);
        return s;
    endfunction

    function automatic int cnt_lk(input int a, input int b);
        int s = 0;
        for (int i = a; i <= b; i++) if (i >= 0 && i < NREC) s += int'(lk_at[i]);
        return s;
    endfunction

    initial begin
        int e0, e3, ec, ea, e4, en3, en, er;
        logic [6:0] rb;
        logic [9:0] cw;

        for (int i = 0; i < 3; i++) step(logic'(i % 2), 1'b1);
        chk_eq("rst_locked", 32'(o_locked), 0);
        chk_eq("rst_par_out", 32'(o_par_out), 0);
        chk_eq("rst_valid_seen", 32'(cnt_vld(0, last_e)), 0);

        // Broken training, then a lone comma proves the framer restarted from HUNT.
        e0 = t;
        send_word(CP); send_word(CP); send_word(W023);
        repeat (2) send_word(W023);
        send_word(CP); send_word(W023); send_word(W023);
        chk_eq("brk_locked", 32'(cnt_lk(e0, last_e)), 0);
        chk_eq("brk_valid", 32'(cnt_vld(e0, last_e)), 0);

        // Acquisition with a random lead-in that cannot form a misaligned comma.
        step(1'b0, 1'b1);
        rb = 7'($urandom);
        rb[5] = 1'b1;
        for (int i = 0; i < 7; i++) step(rb[i], 1'b0);
        repeat (3) send_word(CP);
        e3 = last_e;
        repeat (3) send_word(W023);
        chk_eq("acq_lock_early", 32'(lk_at[e3]), 0);
        chk_eq("acq_lock_edge", 32'(lk_at[e3 + 1]), 1);
        chk_eq("acq_no_early_vld", 32'(cnt_vld(e3, e3 + 10)), 0);
        chk_eq("acq_vld", 32'(vld_at[e3 + 11]), 1);
        chk_eq("acq_par_out", 32'(out_at[e3 + 11]), 32'(W023));
        chk_eq("acq_is_comma", 32'(isc_at[e3 + 11]), 0);
        chk_eq("acq_single_vld", 32'(cnt_vld(e3 + 12, e3 + 20)), 0);
        chk_eq("acq_next_vld", 32'(vld_at[e3 + 21]), 1);

        send_word(CP);
        ec = last_e;
        send_word(W023);
        chk_eq("lk_comma_vld", 32'(vld_at[ec + 1]), 1);
        chk_eq("lk_comma_out", 32'(out_at[ec + 1]), 32'(CP));
        chk_eq("lk_comma_flag", 32'(isc_at[ec + 1]), 1);

        // Three misses, then an aligned comma clears the miss count.
        e0 = t;
        step(1'b0, 1'b0);
        repeat (3) send_word(CP);
        repeat (9) step(1'b0, 1'b0);
        send_word(CP);
        ea = last_e;
        repeat (2) send_word(W023);
        chk_eq("miss3_stays_locked", 32'(cnt_lk(e0, last_e)), 32'(last_e - e0 + 1));
        chk_eq("miss3_realign_out", 32'(out_at[ea + 1]), 32'(CP));
        chk_eq("miss3_realign_flag", 32'(isc_at[ea + 1]), 1);

        // Loss of sync after four misaligned commas.
        step(1'b0, 1'b0);
        repeat (4) send_word(CP);
        e4 = last_e;
        repeat (30) step(1'b0, 1'b0);
        chk_eq("loss_hold", 32'(lk_at[e4]), 1);
        chk_eq("loss_drop", 32'(lk_at[e4 + 1]), 0);
        chk_eq("loss_no_vld", 32'(cnt_vld(e4 + 1, last_e)), 0);

        // RD+ comma acquisition.
        step(1'b0, 1'b1);
        repeat (3) send_word(CN);
        en3 = last_e;
        repeat (2) send_word(W023);
        send_word(CN);
        en = last_e;
        send_word(W023);
        chk_eq("rdp_lock_early", 32'(lk_at[en3]), 0);
        chk_eq("rdp_lock_edge", 32'(lk_at[en3 + 1]), 1);
        chk_eq("rdp_vld", 32'(vld_at[en3 + 11]), 1);
        chk_eq("rdp_par_out", 32'(out_at[en3 + 11]), 32'(W023));
        chk_eq("rdp_comma_out", 32'(out_at[en + 1]), 32'(CN));
        chk_eq("rdp_comma_flag", 32'(isc_at[en + 1]), 1);

        // Reset while locked with the word counter at 4.
        for (int i = 0; i < 5; i++) step(W023[i], 1'b0);
        chk_eq("mid_pre_locked", 32'(o_locked), 1);
        step(1'b1, 1'b1);
        chk_eq("mid_rst_locked", 32'(o_locked), 0);
        chk_eq("mid_rst_out", 32'(o_par_out), 0);
        chk_eq("mid_rst_flag", 32'(o_par_is_comma), 0);
        repeat (3) send_word(CP);
        er = last_e;
        repeat (2) send_word(W023);
        chk_eq("reacq_lock_edge", 32'(lk_at[er + 1]), 1);
        chk_eq("reacq_vld", 32'(vld_at[er + 11]), 1);
        chk_eq("reacq_par_out", 32'(out_at[er + 11]), 32'(W023));

        // Random soak: comma trains, random words, bit slips and occasional resets.
        for (int it = 0; it < 200; it++) begin
            case ($urandom_range(0, 5))
                0: repeat ($urandom_range(3, 5)) begin
                    cw = ($urandom_range(0, 1) == 0) ? CP : CN;
                    send_word(cw);
                end
                1: send_word(10'($urandom));
                2: repeat ($urandom_range(1, 9)) step(1'($urandom_range(0, 1)), 1'b0);
                3: begin
                    cw = ($urandom_range(0, 1) == 0) ? CP : CN;
                    send_word(cw);
                end
                4: send_word(W023);
                default: begin
                    if ($urandom_range(0, 9) == 0) step(1'b0, 1'b1);
                    else send_word(10'($urandom));
                end
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
